divisor_arbitro: RTL and testbench
==================================

Name: divisor_arbitro

Overview:
Arbiter and sequencer that shares one 4-bit sequential divider (start/done handshake, quotient/remainder outputs) between two requesters.
- Each requester presents operands with a valid/ready handshake.
- The block grants round-robin, pulses the divider start, waits for a qualified done and returns the result to the owner as a one-cycle response.
- Divide-by-zero is answered locally without using the divider.
- A stalled divider is recovered by a watchdog timeout.

Parameters:
TIMEOUT, 64, max cycles spent in WAIT before forcing an error response (≥2).

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 accepted this cycle when req0_valid&req0_ready
req0_dividendo  in  4  requester 0 dividend
req0_divisor  in  4  requester 0 divisor
rsp0_valid  out  1  one-cycle result pulse to requester 0
rsp0_cociente  out  4  quotient to requester 0
rsp0_resto  out  4  remainder to requester 0
rsp0_err  out  1  error flag (div-by-zero or timeout), valid with rsp0_valid
req1_valid, req1_ready, req1_dividendo, req1_divisor, rsp1_valid, rsp1_cociente, rsp1_resto, rsp1_err:  same as requester 0, for requester 1
div_start  out  1  one-cycle start pulse to divider
div_dividendo  out  4  registered operand to divider, stable from start until done
div_divisor  out  4  registered operand to divider
div_cociente  in  4  divider quotient
div_resto  in  4  divider remainder
div_done  in  1  divider completion (level or pulse)

Behaviour:
- Reset (rst=1 at a clock edge) produces the following state:
  - FSM goes to IDLE.
  - div_start, rsp*_valid and rsp*_err are 0; rsp*_cociente, rsp*_resto, div_dividendo and div_divisor are 0.
  - Priority pointer is set to requester 0, the timer is cleared and done_q is cleared.
  - Reset mid-operation abandons the transaction with no response; the divider is not re-pulsed.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = pointer's requester if its valid is high, else the other requester if its valid is high.
  - reqN_ready = (state==IDLE) & (grant==N), combinational; at most one ready high per cycle; both ready low outside IDLE.
  - On accept with divisor≠0: latch operands and owner, go to ISSUE.
  - On accept with divisor==0: go to RESP with err=1, cociente=4'hF, resto=dividendo.
- ISSUE:
  - div_start=1 for exactly this cycle; clear the timer; go to WAIT.
- WAIT:
  - Completion is the rising edge of div_done (div_done & ~done_q, where done_q = div_done registered every cycle).
  - A done already high at start is ignored until it falls and rises again.
  - On completion: capture div_cociente/div_resto, err=0, go to RESP.
  - Otherwise the timer increments. When the timer reaches TIMEOUT: err=1, cociente=0, resto=0, go to RESP.
  - Completion and timeout in the same cycle: completion wins, err=0.
- RESP:
  - rsp<owner>_valid=1 for one cycle with the result fields; the other requester's rsp_valid stays 0.
  - Pointer moves to the non-owner (last served gets lowest priority).
  - Return to IDLE; new accept is possible the next cycle.
- Result field retention:
  - rsp*_cociente/resto/err hold their last value between pulses.
  - Only the owner's fields update.
- Latency (accept at cycle 0):
  - div_start at cycle 1.
  - Normal: rsp_valid at cycle D+1, where D is the cycle in which the div_done rising edge is sampled.
  - Divide-by-zero: rsp_valid at cycle 1, no div_start.
  - Throughput: at most one operation in flight.
- Operand capture:
  - Requester operands are captured only at accept; changes afterwards have no effect.
  - A requester holding valid after accept is treated as a new request in the next IDLE.
- Widths and timer:
  - All data is 4-bit unsigned; no arithmetic performed locally.
  - Timer width is $clog2(TIMEOUT+1).

Test Plan:
- Single request: req0 12/5 -> one div_start, rsp0_valid once, cociente=2, resto=2, err=0, rsp1_valid never high.
- Simultaneous contention:
  - Stimulus: after reset, req0 (15/4) and req1 (9/3) both held valid.
  - Required order: req0 served first (Q=3, R=3), then req1 (Q=3, R=0).
  - A second pair of requests is served req1 first, proving the round-robin alternation.
- Divide-by-zero: req1 7/0 -> rsp1_valid at cycle 1, err=1, cociente=15, resto=7, div_start never asserted.
- Timeout: divider model never raises done, TIMEOUT=8 -> rsp0_valid exactly 8 cycles after WAIT entry, err=1, Q=R=0, then IDLE accepts req1.
- Stale done:
  - Stimulus: div_done held high from a prior operation when start is issued.
  - Required: no response until done falls and re-rises, and results are captured at that rise.
- Reset mid-WAIT:
  - Stimulus: rst=1 for 1 cycle during WAIT.
  - Required: all outputs 0, no rsp pulse, pointer at requester 0; the next req0 10/3 returns Q=3, R=1.
- Exhaustive sweep: all A=0..15, B=1..15 alternately via req0 and req1, compared against A/B and A%B.

Source files
------------

// File: rtl/divisor_arbitro.sv
// Round-robin arbiter sharing one 4-bit sequential divider between two requesters.
// Divide-by-zero is answered locally; a watchdog recovers a divider that never finishes.
module divisor_arbitro #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_dividendo,
    input  logic [3:0] req0_divisor,
    output logic       rsp0_valid,
    output logic [3:0] rsp0_cociente,
    output logic [3:0] rsp0_resto,
    output logic       rsp0_err,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_dividendo,
    input  logic [3:0] req1_divisor,
    output logic       rsp1_valid,
    output logic [3:0] rsp1_cociente,
    output logic [3:0] rsp1_resto,
    output logic       rsp1_err,
    output logic       div_start,
    output logic [3:0] div_dividendo,
    output logic [3:0] div_divisor,
    input  logic [3:0] div_cociente,
    input  logic [3:0] div_resto,
    input  logic       div_done
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic          ptr, owner, done_q;
    logic [TW-1:0] timer;
    logic          grant_ok, grant;
    logic [3:0]    sel_a, sel_b;
    logic          done_edge, timeout_hit;
    logic          load, load_who, load_err;
    logic [3:0]    load_q, load_r;

    // Pointer's requester first, otherwise the other one.
    always_comb begin
        grant_ok = 1'b0;
        grant    = ptr;
        if (ptr ? req1_valid : req0_valid) begin
            grant_ok = 1'b1;
            grant    = ptr;
        end else if (ptr ? req0_valid : req1_valid) begin
            grant_ok = 1'b1;
            grant    = ~ptr;
        end
    end

    assign sel_a       = grant ? req1_dividendo : req0_dividendo;
    assign sel_b       = grant ? req1_divisor   : req0_divisor;
    assign done_edge   = div_done & ~done_q;
    assign timeout_hit = (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        div_start  = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        load       = 1'b0;
        load_who   = owner;
        load_err   = 1'b0;
        load_q     = '0;
        load_r     = '0;
        case (state)
            IDLE: begin
                req0_ready = grant_ok & ~grant;
                req1_ready = grant_ok & grant;
                if (grant_ok) begin
                    if (sel_b == '0) begin
                        state_nxt = RESP;
                        load      = 1'b1;
                        load_who  = grant;
                        load_err  = 1'b1;
                        load_q    = '1;
                        load_r    = sel_a;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                div_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                // A completion in the timeout cycle still wins.
                if (done_edge) begin
                    state_nxt = RESP;
                    load      = 1'b1;
                    load_q    = div_cociente;
                    load_r    = div_resto;
                end else if (timeout_hit) begin
                    state_nxt = RESP;
                    load      = 1'b1;
                    load_err  = 1'b1;
                end
            end
            RESP: begin
                rsp0_valid = ~owner;
                rsp1_valid = owner;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= 1'b0;
            owner         <= 1'b0;
            done_q        <= 1'b0;
            timer         <= '0;
            div_dividendo <= '0;
            div_divisor   <= '0;
            rsp0_cociente <= '0;
            rsp0_resto    <= '0;
            rsp0_err      <= 1'b0;
            rsp1_cociente <= '0;
            rsp1_resto    <= '0;
            rsp1_err      <= 1'b0;
        end else begin
            done_q <= div_done;
            if (state == IDLE && grant_ok) begin
                owner <= grant;
                if (sel_b != '0) begin
                    div_dividendo <= sel_a;
                    div_divisor   <= sel_b;
                end
            end
            if (state == ISSUE)
                timer <= '0;
            else if (state == WAIT && !load)
                timer <= timer + TW'(1);
            if (state == RESP)
                ptr <= ~owner;
            // Result fields are loaded on entry to RESP so they are valid with the pulse.
            if (load && !load_who) begin
                rsp0_cociente <= load_q;
                rsp0_resto    <= load_r;
                rsp0_err      <= load_err;
            end
            if (load && load_who) begin
                rsp1_cociente <= load_q;
                rsp1_resto    <= load_r;
                rsp1_err      <= load_err;
            end
        end
    end
endmodule

// File: tb/tb_divisor_arbitro.sv
// Bench for divisor_arbitro: behavioural divider, randomized traffic and a
// spec-level reference (plain A/B, A%B, round-robin pointer, latency rules).
module tb_divisor_arbitro;
    localparam int unsigned TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, rsp0_valid, rsp0_err;
    logic [3:0] req0_dividendo, req0_divisor, rsp0_cociente, rsp0_resto;
    logic       req1_valid, req1_ready, rsp1_valid, rsp1_err;
    logic [3:0] req1_dividendo, req1_divisor, rsp1_cociente, rsp1_resto;
    logic       div_start, div_done;
    logic [3:0] div_dividendo, div_divisor, div_cociente, div_resto;

    always #5 clk = ~clk;

    divisor_arbitro #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_dividendo(req0_dividendo), .req0_divisor(req0_divisor),
        .rsp0_valid(rsp0_valid), .rsp0_cociente(rsp0_cociente),
        .rsp0_resto(rsp0_resto), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_dividendo(req1_dividendo), .req1_divisor(req1_divisor),
        .rsp1_valid(rsp1_valid), .rsp1_cociente(rsp1_cociente),
        .rsp1_resto(rsp1_resto), .rsp1_err(rsp1_err),
        .div_start(div_start), .div_dividendo(div_dividendo), .div_divisor(div_divisor),
        .div_cociente(div_cociente), .div_resto(div_resto), .div_done(div_done)
    );

    // Divider environment: random latency, pulse or level done; or manual control.
    logic       manual = 1'b0, man_done = 1'b0;
    logic [3:0] man_q = '0, man_r = '0;
    logic       mdl_done = 1'b0, busy = 1'b0, lvl = 1'b0;
    logic [3:0] mdl_q = '0, mdl_r = '0, la = '0, lb = 4'd1;
    int         cnt = 0;

    assign div_done     = manual ? man_done : mdl_done;
    assign div_cociente = manual ? man_q : mdl_q;
    assign div_resto    = manual ? man_r : mdl_r;

    always @(posedge clk) begin
        if (div_start) begin
            busy     <= 1'b1;
            cnt      <= int'($urandom_range(0, 3));
            lvl      <= 1'($urandom_range(0, 1));
            la       <= div_dividendo;
            lb       <= div_divisor;
            mdl_done <= 1'b0;
            mdl_q    <= 4'($urandom);
            mdl_r    <= 4'($urandom);
        end else if (busy) begin
            if (cnt == 0) begin
                busy     <= 1'b0;
                mdl_done <= 1'b1;
                mdl_q    <= la / lb;
                mdl_r    <= la % lb;
            end else begin
                cnt <= cnt - 1;
            end
        end else if (!lvl) begin
            mdl_done <= 1'b0;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int starts = 0, start_cyc = -1, rsp0_cnt = 0, rsp1_cnt = 0, both_cnt = 0, rise_cyc = -1;
    bit done_seen = 1'b0;
    bit model_ptr = 1'b0;
    always @(negedge clk) begin
        if (div_start) begin starts++; start_cyc = cyc; end
        if (rsp0_valid) begin rsp0_cnt++; model_ptr = 1'b1; end
        if (rsp1_valid) begin rsp1_cnt++; model_ptr = 1'b0; end
        if (req0_ready && req1_ready) both_cnt++;
        if (div_done && !done_seen) rise_cyc = cyc;
        done_seen = div_done;
    end

    int checks = 0, passes = 0;

    task automatic send(input bit who, input logic [3:0] a, input logic [3:0] b,
                        output logic [3:0] q, output logic [3:0] r, output logic e,
                        output int acc, output int rc, output bit ok);
        int n;
        q = '0; r = '0; e = 1'b0; acc = -1; rc = -1; ok = 1'b0;
        if (who) begin req1_dividendo = a; req1_divisor = b; req1_valid = 1'b1; end
        else     begin req0_dividendo = a; req0_divisor = b; req0_valid = 1'b1; end
        #1;
        n = 0;
        while (!(who ? req1_ready : req0_ready) && n < 200) begin @(negedge clk); #1; n++; end
        if (!(who ? req1_ready : req0_ready)) begin
            if (who) req1_valid = 1'b0; else req0_valid = 1'b0;
            return;
        end
        acc = cyc;
        @(negedge clk);
        if (who) begin req1_valid = 1'b0; req1_dividendo = 4'($urandom); req1_divisor = 4'($urandom); end
        else     begin req0_valid = 1'b0; req0_dividendo = 4'($urandom); req0_divisor = 4'($urandom); end
        #1;
        n = 1;
        while (!(who ? rsp1_valid : rsp0_valid) && n < 64) begin @(negedge clk); #1; n++; end
        if (who ? rsp1_valid : rsp0_valid) begin
            rc = cyc;
            q  = who ? rsp1_cociente : rsp0_cociente;
            r  = who ? rsp1_resto    : rsp0_resto;
            e  = who ? rsp1_err      : rsp0_err;
            ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_ptr = 1'b0;
        #1;
        checks++; if ({div_start, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000", {div_start, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}); else passes++;
        checks++; if ({rsp0_cociente, rsp0_resto, rsp1_cociente, rsp1_resto, div_dividendo, div_divisor} !== 24'h0)
            $display("FAIL reset_data: got %h want 0", {rsp0_cociente, rsp0_resto, rsp1_cociente, rsp1_resto, div_dividendo, div_divisor}); else passes++;
        req0_valid = 1'b1; req1_valid = 1'b1; req0_divisor = 4'd1; req1_divisor = 4'd1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10)
            $display("FAIL reset_ptr: got %b want 10", {req0_ready, req1_ready}); else passes++;
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_contention();
        logic [3:0] q0, r0, q1, r1, q, r;
        logic e0, e1, e;
        int a0, c0, a1, c1, a, c;
        bit ok0, ok1, ok, exp_first;
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            exp_first = model_ptr;
            fork
                send(1'b0, 4'd15, 4'd4, q0, r0, e0, a0, c0, ok0);
                send(1'b1, 4'd9,  4'd3, q1, r1, e1, a1, c1, ok1);
            join
            checks++; if ({ok0, ok1} !== 2'b11) $display("FAIL cont_done%0d: got %b want 11", pass, {ok0, ok1}); else passes++;
            checks++; if ((c1 < c0) !== exp_first) $display("FAIL cont_order%0d: first served %0d want %0d", pass, c1 < c0, exp_first); else passes++;
            checks++; if ({q0, r0, e0} !== {4'd3, 4'd3, 1'b0}) $display("FAIL cont_req0_%0d: got %0d/%0d/%0d want 3/3/0", pass, q0, r0, e0); else passes++;
            checks++; if ({q1, r1, e1} !== {4'd3, 4'd0, 1'b0}) $display("FAIL cont_req1_%0d: got %0d/%0d/%0d want 3/0/0", pass, q1, r1, e1); else passes++;
            if (pass == 0) begin
                send(1'b0, 4'd5, 4'd2, q, r, e, a, c, ok);
                checks++; if ({ok, q, r, e} !== {1'b1, 4'd2, 4'd1, 1'b0}) $display("FAIL cont_mid: got %0d %0d/%0d/%0d want 1 2/1/0", ok, q, r, e); else passes++;
            end
        end
    endtask

    task automatic test_single();
        logic [3:0] q, r; logic e; int a, c, s0, p0, p1; bit ok;
        @(negedge clk);
        s0 = starts; p0 = rsp0_cnt; p1 = rsp1_cnt;
        send(1'b0, 4'd12, 4'd5, q, r, e, a, c, ok);
        repeat (3) @(negedge clk);
        #1;
        checks++; if ({ok, q, r, e} !== {1'b1, 4'd2, 4'd2, 1'b0}) $display("FAIL single_res: got %0d %0d/%0d/%0d want 1 2/2/0", ok, q, r, e); else passes++;
        checks++; if (starts - s0 !== 1) $display("FAIL single_starts: got %0d want 1", starts - s0); else passes++;
        checks++; if (start_cyc !== a + 1) $display("FAIL single_start_lat: got %0d want %0d", start_cyc, a + 1); else passes++;
        checks++; if (c !== rise_cyc + 1) $display("FAIL single_rsp_lat: got %0d want %0d", c, rise_cyc + 1); else passes++;
        checks++; if ({rsp0_cnt - p0, rsp1_cnt - p1} !== {32'd1, 32'd0}) $display("FAIL single_pulses: got %0d,%0d want 1,0", rsp0_cnt - p0, rsp1_cnt - p1); else passes++;
    endtask

    task automatic test_div_zero();
        logic [3:0] q, r, h0q, h0r; logic e, h0e; int a, c, s0; bit ok;
        @(negedge clk);
        s0 = starts; h0q = rsp0_cociente; h0r = rsp0_resto; h0e = rsp0_err;
        send(1'b1, 4'd7, 4'd0, q, r, e, a, c, ok);
        checks++; if ({ok, q, r, e} !== {1'b1, 4'hF, 4'd7, 1'b1}) $display("FAIL dz_res: got %0d %0d/%0d/%0d want 1 15/7/1", ok, q, r, e); else passes++;
        checks++; if (c - a !== 1) $display("FAIL dz_lat: got %0d want 1", c - a); else passes++;
        checks++; if (starts !== s0) $display("FAIL dz_nostart: got %0d starts want 0", starts - s0); else passes++;
        checks++; if ({rsp0_cociente, rsp0_resto, rsp0_err} !== {h0q, h0r, h0e}) $display("FAIL dz_retain: got %h want %h", {rsp0_cociente, rsp0_resto, rsp0_err}, {h0q, h0r, h0e}); else passes++;
    endtask

    task automatic test_timeout();
        logic [3:0] q0, r0, q1, r1; logic e0, e1; int a0, c0, a1, c1; bit ok0, ok1;
        @(negedge clk);
        manual = 1'b1; man_done = 1'b0;
        fork
            begin
                send(1'b0, 4'd13, 4'd3, q0, r0, e0, a0, c0, ok0);
                manual = 1'b0;
            end
            begin
                repeat (3) @(negedge clk);
                send(1'b1, 4'd6, 4'd4, q1, r1, e1, a1, c1, ok1);
            end
        join
        checks++; if ({ok0, q0, r0, e0} !== {1'b1, 4'd0, 4'd0, 1'b1}) $display("FAIL to_res: got %0d %0d/%0d/%0d want 1 0/0/1", ok0, q0, r0, e0); else passes++;
        checks++; if (c0 - a0 !== int'(TO) + 2) $display("FAIL to_lat: got %0d want %0d", c0 - a0, TO + 2); else passes++;
        checks++; if (a1 !== c0 + 1) $display("FAIL to_next_accept: got %0d want %0d", a1, c0 + 1); else passes++;
        checks++; if ({ok1, q1, r1, e1} !== {1'b1, 4'd1, 4'd2, 1'b0}) $display("FAIL to_next_res: got %0d %0d/%0d/%0d want 1 1/2/0", ok1, q1, r1, e1); else passes++;
    endtask

    task automatic test_stale();
        logic [3:0] q, r; logic e; int a, c, s0, p0, rise_at, n; bit ok;
        @(negedge clk);
        manual = 1'b1; man_done = 1'b1; man_q = 4'hF; man_r = 4'hF;
        s0 = starts; rise_at = -1;
        fork
            send(1'b0, 4'd9, 4'd2, q, r, e, a, c, ok);
            begin
                n = 0;
                while (starts == s0 && n < 50) begin @(negedge clk); #1; n++; end
                p0 = rsp0_cnt;
                repeat (3) @(negedge clk);
                #1;
                checks++; if (rsp0_cnt !== p0) $display("FAIL stale_early: got %0d pulses want 0", rsp0_cnt - p0); else passes++;
                man_done = 1'b0;
                @(negedge clk); #1;
                man_q = 4'd4; man_r = 4'd1; man_done = 1'b1; rise_at = cyc;
            end
        join
        man_done = 1'b0; manual = 1'b0;
        checks++; if ({ok, q, r, e} !== {1'b1, 4'd4, 4'd1, 1'b0}) $display("FAIL stale_res: got %0d %0d/%0d/%0d want 1 4/1/0", ok, q, r, e); else passes++;
        checks++; if (c !== rise_at + 1) $display("FAIL stale_lat: got %0d want %0d", c, rise_at + 1); else passes++;
    endtask

    task automatic test_reset_mid_wait();
        logic [3:0] q, r; logic e; int a, c, s0, p0, p1, n; bit ok;
        @(negedge clk);
        manual = 1'b1; man_done = 1'b0;
        req1_dividendo = 4'd9; req1_divisor = 4'd2; req1_valid = 1'b1;
        #1;
        n = 0;
        while (!req1_ready && n < 50) begin @(negedge clk); #1; n++; end
        checks++; if (req1_ready !== 1'b1) $display("FAIL rmw_accept: got %b want 1", req1_ready); else passes++;
        @(negedge clk);
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        s0 = starts; p0 = rsp0_cnt; p1 = rsp1_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; model_ptr = 1'b0;
        #1;
        checks++; if ({div_start, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, req0_ready, req1_ready} !== 7'b0)
            $display("FAIL rmw_ctrl: got %b want 0000000", {div_start, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, req0_ready, req1_ready}); else passes++;
        checks++; if ({rsp0_cociente, rsp0_resto, rsp1_cociente, rsp1_resto, div_dividendo, div_divisor} !== 24'h0)
            $display("FAIL rmw_data: got %h want 0", {rsp0_cociente, rsp0_resto, rsp1_cociente, rsp1_resto, div_dividendo, div_divisor}); else passes++;
        repeat (TO + 4) @(negedge clk);
        #1;
        checks++; if ({starts - s0, rsp0_cnt - p0, rsp1_cnt - p1} !== 96'h0)
            $display("FAIL rmw_quiet: got starts %0d rsp %0d,%0d want 0", starts - s0, rsp0_cnt - p0, rsp1_cnt - p1); else passes++;
        manual = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; req0_divisor = 4'd1; req1_divisor = 4'd1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL rmw_ptr: got %b want 10", {req0_ready, req1_ready}); else passes++;
        req0_valid = 1'b0; req1_valid = 1'b0;
        send(1'b0, 4'd10, 4'd3, q, r, e, a, c, ok);
        checks++; if ({ok, q, r, e} !== {1'b1, 4'd3, 4'd1, 1'b0}) $display("FAIL rmw_after: got %0d %0d/%0d/%0d want 1 3/1/0", ok, q, r, e); else passes++;
    endtask

    task automatic test_sweep();
        logic [3:0] q, r; logic e; int acc, c; bit ok, who;
        who = 1'b0;
        @(negedge clk);
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                send(who, 4'(a), 4'(b), q, r, e, acc, c, ok);
                checks++; if ({ok, q, r, e} !== {1'b1, 4'(a / b), 4'(a % b), 1'b0})
                    $display("FAIL sweep %0d/%0d: got %0d %0d/%0d/%0d want 1 %0d/%0d/0", a, b, ok, q, r, e, a / b, a % b); else passes++;
                checks++; if (c !== rise_cyc + 1) $display("FAIL sweep_lat %0d/%0d: got %0d want %0d", a, b, c, rise_cyc + 1); else passes++;
                who = ~who;
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        fork
            begin
                logic [3:0] q, r, a, b; logic e; int acc, c; bit ok;
                for (int i = 0; i < 20; i++) begin
                    a = 4'($urandom); b = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                    send(1'b0, a, b, q, r, e, acc, c, ok);
                    checks++; if ({ok, q, r, e} !== ((b == 0) ? {1'b1, 4'hF, a, 1'b1} : {1'b1, a / b, a % b, 1'b0}))
                        $display("FAIL b2b_req0 %0d/%0d: got %0d %0d/%0d/%0d", a, b, ok, q, r, e); else passes++;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            begin
                logic [3:0] q, r, a, b; logic e; int acc, c; bit ok;
                for (int i = 0; i < 20; i++) begin
                    a = 4'($urandom); b = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                    send(1'b1, a, b, q, r, e, acc, c, ok);
                    checks++; if ({ok, q, r, e} !== ((b == 0) ? {1'b1, 4'hF, a, 1'b1} : {1'b1, a / b, a % b, 1'b0}))
                        $display("FAIL b2b_req1 %0d/%0d: got %0d %0d/%0d/%0d", a, b, ok, q, r, e); else passes++;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
        join
        checks++; if (both_cnt !== 0) $display("FAIL one_ready: got %0d cycles with both ready want 0", both_cnt); else passes++;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_dividendo = '0; req0_divisor = '0;
        req1_valid = 1'b0; req1_dividendo = '0; req1_divisor = '0;
        test_reset();
        test_contention();
        test_single();
        test_div_zero();
        test_timeout();
        test_stale();
        test_reset_mid_wait();
        test_sweep();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
        $fatal(1);
    end
endmodule
